// File: rtl/fifo_ram_2p.sv
// Dual-port storage array for sync_fifo_lvl: one synchronous write port and one
// asynchronous read port. Contents are never reset.
module fifo_ram_2p #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       we_i,
    input  logic [$clog2(DEPTH)-1:0]   waddr_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic [$clog2(DEPTH)-1:0]   raddr_i,
    output logic [WIDTH-1:0]           rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write port: stores one word per accepted write.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_lvl.sv
// Synchronous FIFO with occupancy level, almost-full/empty thresholds, sticky
// overflow/underflow flags and selectable first-word-fall-through read.
module sync_fifo_lvl #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     we_i,
    input  logic                     re_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     almost_full_o,
    output logic                     almost_empty_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overflow_o,
    output logic                     underflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] AF_L    = LW'(AF_THRESH);
    localparam logic [LW-1:0] AE_L    = LW'(AE_THRESH);

    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("sync_fifo_lvl: WIDTH must be at least 1");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("sync_fifo_lvl: DEPTH must be a power of two, at least 2");
        end
        if (!(AE_THRESH < AF_THRESH && AF_THRESH <= DEPTH)) begin : g_bad_thresh
            $error("sync_fifo_lvl: need AE_THRESH < AF_THRESH <= DEPTH");
        end
    endgenerate

    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             rd_acc_s, wr_acc_s;
    logic [WIDTH-1:0] ram_rdata_s;

    // A flush suppresses every accept, so neither pointers nor memory move.
    assign rd_acc_s = re_i && (level_q != {LW{1'b0}}) && !clr_i;
    assign wr_acc_s = we_i && ((level_q != DEPTH_L) || rd_acc_s) && !clr_i;

    // Next-state for pointers, level and sticky error flags.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (clr_i) begin
            wptr_d  = {AW{1'b0}};
            rptr_d  = {AW{1'b0}};
            level_d = {LW{1'b0}};
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else begin
            if (wr_acc_s) begin
                wptr_d = wptr_q + AW'(1);
            end else begin
                wptr_d = wptr_q;
            end
            if (rd_acc_s) begin
                rptr_d = rptr_q + AW'(1);
            end else begin
                rptr_d = rptr_q;
            end
            if (wr_acc_s && !rd_acc_s) begin
                level_d = level_q + LW'(1);
            end else if (rd_acc_s && !wr_acc_s) begin
                level_d = level_q - LW'(1);
            end else begin
                level_d = level_q;
            end
            if (we_i && !wr_acc_s) begin
                ovf_d = 1'b1;
            end else begin
                ovf_d = ovf_q;
            end
            if (re_i && (level_q == {LW{1'b0}})) begin
                unf_d = 1'b1;
            end else begin
                unf_d = unf_q;
            end
        end
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= {AW{1'b0}};
            rptr_q  <= {AW{1'b0}};
            level_q <= {LW{1'b0}};
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    fifo_ram_2p #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (wr_acc_s),
        .waddr_i (wptr_q),
        .wdata_i (wdata_i),
        .raddr_i (rptr_q),
        .rdata_o (ram_rdata_s)
    );

    generate
        if (FWFT != 0) begin : g_fwft
            assign rdata_o = ram_rdata_s;
        end else begin : g_regd
            logic [WIDTH-1:0] rdata_q;

            // Output register loads the popped word and holds it until the next pop.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    rdata_q <= {WIDTH{1'b0}};
                end else if (clr_i) begin
                    rdata_q <= {WIDTH{1'b0}};
                end else if (rd_acc_s) begin
                    rdata_q <= ram_rdata_s;
                end else begin
                    rdata_q <= rdata_q;
                end
            end

            assign rdata_o = rdata_q;
        end
    endgenerate

    assign level_o        = level_q;
    assign full_o         = (level_q == DEPTH_L);
    assign empty_o        = (level_q == {LW{1'b0}});
    assign almost_full_o  = (level_q >= AF_L);
    assign almost_empty_o = (level_q <= AE_L);
    assign overflow_o     = ovf_q;
    assign underflow_o    = unf_q;

endmodule

// File: doc/sync_fifo_lvl.md
SYNC_FIFO_LVL -- requirements
Module: sync_fifo_lvl

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data word width in bits, at least 1.
REQ-002 SHALL have parameter DEPTH, default 16: number of entries, a power of two and at least 2.
REQ-003 SHALL have parameter AF_THRESH, default DEPTH-2: almost_full_o asserts when level >= AF_THRESH.
REQ-004 SHALL have parameter AE_THRESH, default 2: almost_empty_o asserts when level <= AE_THRESH.
REQ-005 SHALL have parameter FWFT, default 1: 1 = first-word-fall-through, 0 = registered read.
REQ-006 SHALL have port clk_i, input, 1 bit: clock, rising edge.
REQ-007 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port clr_i, input, 1 bit: synchronous flush.
REQ-009 SHALL have port wdata_i, input, WIDTH bits: write data.
REQ-010 SHALL have port we_i, input, 1 bit: write request.
REQ-011 SHALL have port re_i, input, 1 bit: read request.
REQ-012 SHALL have port rdata_o, output, WIDTH bits: read data.
REQ-013 SHALL have ports full_o, empty_o, almost_full_o and almost_empty_o, each output, 1 bit: status flags.
REQ-014 SHALL have port level_o, output, $clog2(DEPTH)+1 bits: current occupancy, 0..DEPTH.
REQ-015 SHALL have ports overflow_o and underflow_o, each output, 1 bit: sticky error flags.

Function
REQ-016 SHALL accept a read (rd_acc) when re_i=1 and level != 0.
REQ-017 SHALL accept a write (wr_acc) when we_i=1 and either level != DEPTH or rd_acc=1 in the same cycle; writing while full is legal only with a simultaneous accepted read.
REQ-018 SHALL write wdata_i to mem[wptr] on wr_acc, advance wptr modulo DEPTH, and advance rptr modulo DEPTH on rd_acc.
REQ-019 SHALL update level on the next clock edge: +1 on wr_acc only, -1 on rd_acc only, and unchanged when both or neither occur.
REQ-020 SHALL derive full_o (level==DEPTH), empty_o (level==0), almost_full_o and almost_empty_o combinationally from the registered level, so each flag reflects an accept one cycle after it.
REQ-021 SHALL, when FWFT=1, drive rdata_o = mem[rptr] combinationally; the data is valid whenever empty_o=0, and rd_acc pops that word.
REQ-022 SHALL, when FWFT=0, load rdata_o from mem[rptr] into an output register on rd_acc, making it valid one cycle after the accept and holding it until the next rd_acc.
REQ-023 SHALL NOT make a word written in cycle N readable before cycle N+1, including when the FIFO is empty.
REQ-024 SHALL set overflow_o when we_i=1 and wr_acc=0, and SHALL hold it until clr_i or reset.
REQ-025 SHALL set underflow_o when re_i=1 and level==0, and SHALL hold it until clr_i or reset.
REQ-026 SHALL, on clr_i=1, clear wptr, rptr, level, overflow_o, underflow_o and the FWFT=0 output register on the next edge.
REQ-027 SHALL give clr_i priority over we_i and re_i in the same cycle: no write is accepted and no error flag is set.
REQ-028 SHALL NOT require memory contents to be cleared by clr_i or reset.

Reset
REQ-029 SHALL, while rst_ni=0, force wptr=0, rptr=0, level_o=0, empty_o=1, full_o=0, almost_empty_o=1, almost_full_o=(AF_THRESH==0), overflow_o=0 and underflow_o=0.
REQ-030 SHALL, while rst_ni=0, force the FWFT=0 output register to 0.
REQ-031 SHALL abandon any in-flight accept when reset asserts mid-operation, without corrupting the post-reset state.

Structure
REQ-032 SHALL need no shared package; the address width $clog2(DEPTH) and level width are localparams.
REQ-033 SHALL instantiate one sub-module, fifo_ram_2p (parametrised WIDTH/DEPTH, one synchronous write port, one asynchronous read port) to hold the storage.
REQ-034 SHALL check parameter legality at elaboration: DEPTH a power of two, AE_THRESH < AF_THRESH <= DEPTH.

Verification (WIDTH=8, DEPTH=4, AF_THRESH=3, AE_THRESH=1 unless noted)
REQ-035 SHALL cover fill then drain: write 0x11,0x22,0x33,0x44 -> level 1,2,3,4; almost_full_o at level 3; full_o at 4; reads return 0x11..0x44 in order; empty_o at end.
REQ-036 SHALL cover a write when full: with the FIFO full, we_i=1, re_i=0, data 0x55 -> not stored, overflow_o=1 and sticky, level stays 4.
REQ-037 SHALL cover a simultaneous read and write when full: we_i=1, re_i=1 -> 0x11 popped, 0x55 stored, level stays 4, no overflow.
REQ-038 SHALL cover a read when empty: re_i=1 -> underflow_o=1, level stays 0; a following clr_i clears underflow_o.
REQ-039 SHALL cover wrap-around: 10 interleaved write/read pairs of 0x00..0x09 -> data in order and pointers wrap correctly.
REQ-040 SHALL cover FWFT=0: write 0xA5, then pulse re_i -> rdata_o=0xA5 exactly one cycle after the accept; clr_i with re_i in the same cycle -> rdata_o=0 and no pop.
